// File: rtl/song_player.sv
// rtl/song_player.sv - sequenced note-enable player driven by a small writable song memory
// Each entry plays its note mask for (dur+1) beats, then a silent gap, until the last-step entry.
module song_player #(
  parameter int BEAT_TICKS = 12500000,
  parameter int GAP_TICKS  = 1250000,
  parameter int SONG_LEN   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop,
  input  logic                        wr_en,
  input  logic [$clog2(SONG_LEN)-1:0] wr_addr,
  input  logic [10:0]                 wr_data,
  output logic                        En_C,
  output logic                        En_D,
  output logic                        En_E,
  output logic                        En_F,
  output logic                        En_G,
  output logic                        En_A,
  output logic                        En_B,
  output logic                        En_C2,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(SONG_LEN)-1:0] step
);

  localparam int AW   = $clog2(SONG_LEN);
  localparam int MAXT = (4 * BEAT_TICKS > GAP_TICKS) ? 4 * BEAT_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  // Counters are loaded with length-1 and count down to zero.
  localparam logic [CW-1:0] NOTE1_M1 = CW'(BEAT_TICKS - 1);
  localparam logic [CW-1:0] NOTE2_M1 = CW'(2 * BEAT_TICKS - 1);
  localparam logic [CW-1:0] NOTE3_M1 = CW'(3 * BEAT_TICKS - 1);
  localparam logic [CW-1:0] NOTE4_M1 = CW'(4 * BEAT_TICKS - 1);
  localparam logic [CW-1:0] GAP_M1   = CW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   step_q, step_d;
  logic [10:0]     entry_q, entry_d;
  logic [7:0]      en_q, en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [10:0]     mem_q [SONG_LEN];
  logic            last_w;
  logic [AW-1:0]   nstep_w;
  logic [10:0]     nent_w;

  function automatic logic [CW-1:0] note_len_m1(input logic [1:0] dur);
    case (dur)
      2'd0:    return NOTE1_M1;
      2'd1:    return NOTE2_M1;
      2'd2:    return NOTE3_M1;
      default: return NOTE4_M1;
    endcase
  endfunction

  // Song memory has no reset so a stored song survives a player reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset && state_q == S_IDLE) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign last_w  = entry_q[10] || (step_q == AW'(SONG_LEN - 1));
  assign nstep_w = last_w ? '0 : step_q + 1'b1;
  assign nent_w  = mem_q[nstep_w];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    entry_d = entry_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      step_d  = '0;
      en_d    = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_NOTE;
            step_d  = '0;
            entry_d = mem_q[0];
            en_d    = mem_q[0][7:0];
            cnt_d   = note_len_m1(mem_q[0][9:8]);
            busy_d  = 1'b1;
          end
        end
        S_NOTE: begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            cnt_d   = GAP_M1;
            en_d    = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!last_w || loop) begin
            state_d = S_NOTE;
            step_d  = nstep_w;
            entry_d = nent_w;
            en_d    = nent_w[7:0];
            cnt_d   = note_len_m1(nent_w[9:8]);
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          step_d  = '0;
          en_d    = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      entry_q <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      entry_q <= entry_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign En_C  = en_q[0];
  assign En_D  = en_q[1];
  assign En_E  = en_q[2];
  assign En_F  = en_q[3];
  assign En_G  = en_q[4];
  assign En_A  = en_q[5];
  assign En_B  = en_q[6];
  assign En_C2 = en_q[7];
  assign busy  = busy_q;
  assign done  = done_q;
  assign step  = step_q;

endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - scoreboard bench for song_player
// Expected per-cycle outputs come from a step-by-step song model; a negedge monitor compares them.
module tb_song_player;
  localparam int BEAT = 4;
  localparam int GAP  = 2;
  localparam int LEN  = 4;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop, wr_en;
  logic [1:0]  wr_addr;
  logic [10:0] wr_data;
  logic        En_C, En_D, En_E, En_F, En_G, En_A, En_B, En_C2;
  logic        busy, done;
  logic [1:0]  step;

  logic [10:0] mem_m [LEN];
  logic [11:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          mon_idx = 0;

  song_player #(.BEAT_TICKS(BEAT), .GAP_TICKS(GAP), .SONG_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .En_C(En_C), .En_D(En_D), .En_E(En_E), .En_F(En_F),
    .En_G(En_G), .En_A(En_A), .En_B(En_B), .En_C2(En_C2),
    .busy(busy), .done(done), .step(step)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] act();
    return {En_C2, En_B, En_A, En_G, En_F, En_E, En_D, En_C, busy, done, step};
  endfunction

  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      logic [11:0] e;
      logic [11:0] a;
      e = exp_q.pop_front();
      a = act();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace[%0d] {en,busy,done,step}: got en=%h busy=%b done=%b step=%0d, want en=%h busy=%b done=%b step=%0d",
                 mon_idx, a[11:4], a[3], a[2], a[1:0], e[11:4], e[3], e[2], e[1:0]);
      end
      mon_idx++;
    end
  end

  task automatic exp_push(input logic [7:0] en, input logic b, input logic d, input logic [1:0] s);
    exp_q.push_back({en, b, d, s});
  endtask

  task automatic push_idle(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) exp_push(8'h00, 1'b0, 1'b0, s);
  endtask

  // Song model: walks entries in order; stop_k>0 means the player is stopped at trace index stop_k.
  task automatic push_run(input bit lp, input int stop_k);
    int n = 0;
    int s = 0;
    int note;
    logic [10:0] e;
    forever begin
      e = mem_m[s];
      note = (int'(e[9:8]) + 1) * BEAT;
      for (int c = 0; c < note + GAP; c++) begin
        if (stop_k > 0 && n == stop_k) begin
          push_idle(2'd0, 3);
          return;
        end
        exp_push((c < note) ? e[7:0] : 8'h00, 1'b1, 1'b0, 2'(s));
        n++;
      end
      if (e[10] || s == LEN - 1) begin
        if (!lp) begin
          exp_push(8'h00, 1'b0, 1'b1, 2'(s));
          push_idle(2'(s), 2);
          return;
        end
        s = 0;
      end else begin
        s++;
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic mem_write(input logic [1:0] a, input logic [10:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic run_song(input bit lp, input int stop_k, input bit wr_busy);
    loop = lp;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    push_run(lp, stop_k);
    if (wr_busy) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 11'h0FF;
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    if (stop_k > 0) begin
      repeat (stop_k - 1) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
    end
    wait_drain();
    loop = 1'b0;
  endtask

  initial begin
    int stop_k;
    bit lp;
    logic [10:0] d;

    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #12;
    checks++;
    if (act() !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h want 000", act());
    end
    @(posedge clk); #1 reset = 1'b0;

    mem_write(2'd0, 11'h001);
    mem_write(2'd1, 11'h110);
    mem_write(2'd2, 11'h480);
    mem_write(2'd3, 11'h0AA);

    run_song(1'b0, 0, 1'b0);
    run_song(1'b1, 25, 1'b0);
    run_song(1'b0, 9, 1'b0);

    // start and stop together in IDLE must stay idle with step cleared
    @(posedge clk); #1; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    push_idle(2'd0, 3);
    wait_drain();

    run_song(1'b0, 0, 1'b1);
    run_song(1'b0, 0, 1'b0);

    mem_write(2'd1, 11'h000);
    run_song(1'b0, 0, 1'b0);
    mem_write(2'd1, 11'h110);

    // asynchronous reset in the middle of step 0's note
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (act() !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got %h want 000", act());
    end
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    push_idle(2'd0, 3);
    wait_drain();
    run_song(1'b0, 0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < LEN; a++) begin
        d[10]  = ($urandom_range(0, 2) == 0);
        d[9:8] = 2'($urandom_range(0, 3));
        d[7:0] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        mem_write(2'(a), d);
      end
      lp = 1'($urandom_range(0, 1));
      if (lp) stop_k = $urandom_range(1, 80);
      else    stop_k = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0;
      run_song(lp, stop_k, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
